// File: rtl/bsg_mem_rv_pkg.sv
// Shared constants and types for the ready/valid front-end of the byte-masked 1rw memory.
// The enum is used only when BSG_MEM_1RW_RV_WRITE_ACK_EN is defined.
package bsg_mem_rv_pkg;

    // Response buffer depth; it is also the number of responses that may be owed at once.
    localparam int resp_els_lp       = 2;
    localparam int resp_cnt_width_lp = $clog2(resp_els_lp + 1);
    localparam int resp_ptr_width_lp = $clog2(resp_els_lp);

    typedef enum logic {
        e_rv_read  = 1'b0,
        e_rv_write = 1'b1
    } rv_kind_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_rv_resp_fifo.sv
// Two-entry response buffer: v/ready enqueue, v/yumi dequeue, occupancy count.
// A full buffer still accepts an enqueue in the cycle its head is dequeued.
module bsg_mem_rv_resp_fifo
    import bsg_mem_rv_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [resp_cnt_width_lp-1:0] count_o
);

    logic [width_p-1:0]           mem_r [resp_els_lp];
    logic [resp_ptr_width_lp-1:0] rptr_r;
    logic [resp_ptr_width_lp-1:0] wptr_r;
    logic [resp_cnt_width_lp-1:0] count_r;
    logic                         enq;
    logic                         deq;

    assign v_o     = (count_r != '0);
    assign ready_o = (count_r != resp_cnt_width_lp'(resp_els_lp)) | yumi_i;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + resp_ptr_width_lp'(1);
            if (deq) rptr_r <= rptr_r + resp_ptr_width_lp'(1);
            count_r <= count_r + resp_cnt_width_lp'(enq) - resp_cnt_width_lp'(deq);
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_rv.sv
// Ready/valid front-end for a synchronous byte-masked 1rw memory with an in-order response buffer.
// Define BSG_MEM_1RW_RV_WRITE_ACK_EN to make writes take a credit and return an all-zero response.
module bsg_mem_1rw_sync_mask_write_byte_rv
    import bsg_mem_rv_pkg::*;
#(
    parameter int data_width_p        = 32,
    parameter int els_p               = 16,
    parameter int write_mask_width_lp = data_width_p >> 3,
    parameter int addr_width_lp       = safe_clog2(els_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic                           ready_and_o,

    output logic                           v_o,
    output logic [data_width_p-1:0]        data_o,
    input  logic                           yumi_i,

    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [write_mask_width_lp-1:0] mem_write_mask_o,
    input  logic [data_width_p-1:0]        mem_data_i
);

    logic                         inflight_r;
    logic                         inflight_n;
    logic                         accept;
    logic [resp_cnt_width_lp-1:0] credit_count;
    logic [resp_cnt_width_lp-1:0] fifo_count;
    logic                         fifo_v;
    logic                         fifo_ready;
    logic                         fifo_enq_v;
    logic                         fifo_yumi;
    logic [data_width_p-1:0]      fifo_data;
    logic [data_width_p-1:0]      resp_data;

    // Every owed response is either in flight from the memory or sitting in the buffer.
    assign credit_count = fifo_count + resp_cnt_width_lp'(inflight_r);
    assign ready_and_o  = ~reset_i & (credit_count < resp_cnt_width_lp'(resp_els_lp));
    assign accept       = v_i & ready_and_o;

    assign mem_v_o          = accept;
    assign mem_w_o          = w_i;
    assign mem_addr_o       = addr_i;
    assign mem_data_o       = data_i;
    assign mem_write_mask_o = write_mask_i;

`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
    rv_kind_e inflight_kind_r;

    assign inflight_n = accept;

    always_ff @(posedge clk_i) begin
        if (reset_i)     inflight_kind_r <= e_rv_read;
        else if (accept) inflight_kind_r <= w_i ? e_rv_write : e_rv_read;
    end

    assign resp_data = (inflight_kind_r == e_rv_write) ? '0 : mem_data_i;
`else
    assign inflight_n = accept & ~w_i;
    assign resp_data  = mem_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) inflight_r <= 1'b0;
        else         inflight_r <= inflight_n;
    end

    // Memory data is only valid for one cycle, so it is buffered unless taken by the bypass.
    assign fifo_enq_v = inflight_r & ~(~fifo_v & yumi_i) & fifo_ready;
    assign fifo_yumi  = fifo_v & yumi_i;

    bsg_mem_rv_resp_fifo #(
        .width_p (data_width_p)
    ) resp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_enq_v),
        .data_i  (resp_data),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi),
        .count_o (fifo_count)
    );

    assign v_o    = ~reset_i & (fifo_v | inflight_r);
    assign data_o = fifo_v ? fifo_data : resp_data;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_rv.sv
// Bench for bsg_mem_1rw_sync_mask_write_byte_rv: behavioural memory on the mem_* pins, response-queue reference model.
module tb_bsg_mem_1rw_sync_mask_write_byte_rv;

    localparam int DW  = 32;
    localparam int ELS = 16;
    localparam int AW  = 4;
    localparam int MW  = DW / 8;

    logic          clk;
    logic          reset_i;
    logic          v_i, w_i, yumi_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] write_mask_i;
    logic          ready_and_o, v_o;
    logic [DW-1:0] data_o;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [MW-1:0] mem_write_mask_o;
    logic [DW-1:0] mem_data_i;

    bsg_mem_1rw_sync_mask_write_byte_rv #(
        .data_width_p (DW),
        .els_p        (ELS)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .w_i              (w_i),
        .addr_i           (addr_i),
        .data_i           (data_i),
        .write_mask_i     (write_mask_i),
        .ready_and_o      (ready_and_o),
        .v_o              (v_o),
        .data_o           (data_o),
        .yumi_i           (yumi_i),
        .mem_v_o          (mem_v_o),
        .mem_w_o          (mem_w_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_write_mask_o (mem_write_mask_o),
        .mem_data_i       (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte-masked memory: read data appears the cycle after the read.
    logic [DW-1:0] mem [ELS];
    initial for (int i = 0; i < ELS; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_write_mask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_data_i <= mem[mem_addr_o];
            end
        end
    end

    // Reference model: contents as the user sees them, plus the queue of owed responses.
    logic [DW-1:0] ref_mem [ELS];
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;
    int n_pops   = 0;

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic          yumi;
        logic          exp_ready;
        logic          exp_v;
        logic [DW-1:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic w, input int addr, input logic [DW-1:0] data,
                                input logic [MW-1:0] mask, input logic yumi, input logic er,
                                input logic ev, input logic [DW-1:0] ed);
        vec_t t;
        t.v = v; t.w = w; t.addr = AW'(addr); t.data = data; t.mask = mask; t.yumi = yumi;
        t.exp_ready = er; t.exp_v = ev; t.exp_data = ed;
        return t;
    endfunction

    // One cycle: drive at negedge, check before the rising edge, update the model after it.
    task automatic step(input logic rst, input vec_t t, input bit use_tbl, input int row);
        logic exp_ready, exp_v, acc;
        reset_i = rst; v_i = t.v; w_i = t.w; addr_i = t.addr;
        data_i = t.data; write_mask_i = t.mask; yumi_i = t.yumi;
        #1;
        exp_ready = !rst && (exp_q.size() < 2);
        exp_v     = !rst && (exp_q.size() > 0);
        check("ready_and_o", DW'(ready_and_o), DW'(exp_ready));
        check("v_o", DW'(v_o), DW'(exp_v));
        if (exp_v) check("data_o", data_o, exp_q[0]);
        acc = t.v & exp_ready;
        check("mem_v_o", DW'(mem_v_o), DW'(acc));
        if (acc) begin
            check("mem_addr_o", DW'(mem_addr_o), DW'(t.addr));
            check("mem_w_o", DW'(mem_w_o), DW'(t.w));
            if (t.w) check("mem_write_mask_o", DW'(mem_write_mask_o), DW'(t.mask));
        end
        if (use_tbl) begin
            check($sformatf("row%0d ready", row), DW'(ready_and_o), DW'(t.exp_ready));
            check($sformatf("row%0d v", row), DW'(v_o), DW'(t.exp_v));
            if (t.exp_v) check($sformatf("row%0d data", row), data_o, t.exp_data);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (t.yumi && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_pops++;
            end
            if (acc && t.w) begin
                for (int b = 0; b < MW; b++)
                    if (t.mask[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
                exp_q.push_back('0);
`endif
            end else if (acc) begin
                exp_q.push_back(ref_mem[t.addr]);
            end
        end
        @(negedge clk);
    endtask

    function automatic vec_t idle(input logic yumi);
        return mk(1'b0, 1'b0, 0, '0, '0, yumi, 1'b0, 1'b0, '0);
    endfunction

    vec_t vecs [17];

    initial begin
        int pops0;
        vec_t t;
        for (int i = 0; i < ELS; i++) ref_mem[i] = '0;

        //         v     w     addr data          mask     yumi  rdy   v_o   data_o
        vecs[0]  = mk(1'b1, 1'b1, 5, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        vecs[1]  = mk(1'b1, 1'b0, 5, '0,           4'b0000, 1'b0, 1'b1, 1'b0, '0);
        vecs[2]  = mk(1'b0, 1'b0, 0, '0,           4'b0000, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD);
        vecs[3]  = mk(1'b1, 1'b1, 5, 32'h11223344, 4'b0101, 1'b0, 1'b1, 1'b0, '0);
        vecs[4]  = mk(1'b1, 1'b0, 5, '0,           4'b0000, 1'b0, 1'b1, 1'b0, '0);
        vecs[5]  = mk(1'b0, 1'b0, 0, '0,           4'b0000, 1'b1, 1'b1, 1'b1, 32'hAA22CC44);
        vecs[6]  = mk(1'b1, 1'b1, 1, 32'h01010101, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        vecs[7]  = mk(1'b1, 1'b1, 2, 32'h02020202, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        vecs[8]  = mk(1'b1, 1'b1, 3, 32'h03030303, 4'b1111, 1'b0, 1'b1, 1'b0, '0);
        vecs[9]  = mk(1'b1, 1'b0, 1, '0,           4'b0000, 1'b0, 1'b1, 1'b0, '0);
        vecs[10] = mk(1'b1, 1'b0, 2, '0,           4'b0000, 1'b0, 1'b1, 1'b1, 32'h01010101);
        vecs[11] = mk(1'b1, 1'b0, 3, '0,           4'b0000, 1'b0, 1'b0, 1'b1, 32'h01010101);
        vecs[12] = mk(1'b1, 1'b0, 3, '0,           4'b0000, 1'b0, 1'b0, 1'b1, 32'h01010101);
        vecs[13] = mk(1'b1, 1'b0, 3, '0,           4'b0000, 1'b1, 1'b0, 1'b1, 32'h01010101);
        vecs[14] = mk(1'b1, 1'b0, 3, '0,           4'b0000, 1'b1, 1'b1, 1'b1, 32'h02020202);
        vecs[15] = mk(1'b0, 1'b0, 0, '0,           4'b0000, 1'b1, 1'b1, 1'b1, 32'h03030303);
        vecs[16] = mk(1'b0, 1'b0, 0, '0,           4'b0000, 1'b0, 1'b1, 1'b0, '0);

        reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0;
        write_mask_i = '0; yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1'b1, idle(1'b0), 1'b0, 0);

`ifndef BSG_MEM_1RW_RV_WRITE_ACK_EN
        for (int r = 0; r < 17; r++) step(1'b0, vecs[r], 1'b1, r);
`endif

        // Streaming reads with an always-ready consumer: one response per cycle, no stall.
        for (int a = 0; a < ELS; a++)
            step(1'b0, mk(1'b1, 1'b1, a, $urandom, 4'b1111, exp_q.size() > 0, 1'b0, 1'b0, '0), 1'b0, 0);
        while (exp_q.size() > 0) step(1'b0, idle(1'b1), 1'b0, 0);
        pops0 = n_pops;
        for (int a = 0; a < ELS; a++) begin
            step(1'b0, mk(1'b1, 1'b0, a, '0, '0, exp_q.size() > 0, 1'b0, 1'b0, '0), 1'b0, 0);
            if (a > 0) check("stream v_o latency", DW'(exp_q.size()), DW'(1));
        end
        step(1'b0, idle(1'b1), 1'b0, 0);
        check("stream response count", DW'(n_pops - pops0), DW'(ELS));

        // Reset with two reads owed: nothing stale may appear afterwards.
        step(1'b0, mk(1'b1, 1'b0, 2, '0, '0, 1'b0, 1'b0, 1'b0, '0), 1'b0, 0);
        step(1'b0, mk(1'b1, 1'b0, 3, '0, '0, 1'b0, 1'b0, 1'b0, '0), 1'b0, 0);
        check("owed before reset", DW'(exp_q.size()), DW'(2));
        step(1'b1, idle(1'b0), 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
            #1;
            check("post-reset v_o", DW'(v_o), DW'(0));
            check("post-reset ready_and_o", DW'(ready_and_o), DW'(1));
            @(negedge clk);
        end

`ifdef BSG_MEM_1RW_RV_WRITE_ACK_EN
        // Write ack precedes the following read's data.
        step(1'b0, mk(1'b1, 1'b1, 7, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0, 1'b0, '0), 1'b0, 0);
        step(1'b0, mk(1'b1, 1'b0, 7, '0, '0, 1'b1, 1'b1, 1'b1, '0), 1'b1, 100);
        step(1'b0, mk(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D), 1'b1, 101);
`endif

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            t = mk($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, ELS - 1),
                   $urandom, MW'($urandom_range(0, 15)),
                   (exp_q.size() > 0) && ($urandom_range(0, 3) != 0), 1'b0, 1'b0, '0);
            step(1'b0, t, 1'b0, 0);
        end
        for (int c = 0; c < 4 && exp_q.size() > 0; c++) step(1'b0, idle(1'b1), 1'b0, 0);
        check("drained", DW'(exp_q.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_byte_rv.md
Name: bsg_mem_1rw_sync_mask_write_byte_rv

Overview:
- Ready/valid front-end sitting directly upstream of bsg_mem_1rw_sync_mask_write_byte_banked.
- Accepts byte-masked read/write requests over a valid/ready-and handshake and drives the memory's v/w/addr/data/mask pins.
- Captures the synchronous read data, which is valid only the cycle after the read, into a 2-entry response buffer.
- Presents read responses in order over a valid/yumi handshake, so a stalling consumer never loses data.

Parameters:
- data_width_p, none (required), total data width; multiple of 8.
- els_p, none (required), memory depth.
- write_mask_width_lp, data_width_p>>3, byte mask width.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width.
- resp_els_lp, 2, response buffer depth; also the credit limit.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  request valid
- w_i  in  1  1=write, 0=read
- addr_i  in  addr_width_lp  request address
- data_i  in  data_width_p  write data
- write_mask_i  in  write_mask_width_lp  byte write enables
- ready_and_o  out  1  request accepted when v_i & ready_and_o
- v_o  out  1  read response valid
- data_o  out  data_width_p  read response data
- yumi_i  in  1  consumer takes response; legal only when v_o=1
- mem_v_o  out  1  memory enable
- mem_w_o  out  1  memory write
- mem_addr_o  out  addr_width_lp  memory address
- mem_data_o  out  data_width_p  memory write data
- mem_write_mask_o  out  write_mask_width_lp  memory byte mask
- mem_data_i  in  data_width_p  memory read data, valid the cycle after a read

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state: inflight_r=0, buffer empty, v_o=0, ready_and_o=0 while reset_i=1. data_o is don't-care when v_o=0.
- Credits: credit count = inflight_r + buffer count, range 0..2.
- ready_and_o = ~reset_i & (credit count < 2). It is independent of v_i, w_i and yumi_i. There is no same-cycle credit return.
- Memory drive is a combinational pass-through:
  - mem_v_o = v_i & ready_and_o.
  - mem_w_o = w_i.
  - mem_addr_o, mem_data_o and mem_write_mask_o pass through from the request.
- Write: accepted in cycle N and committed by the memory at the N clock edge. Produces no response and consumes no credit.
- Read accepted in cycle N: inflight_r=1 during N+1.
- In N+1 with the buffer empty, bypass: v_o=1, data_o=mem_data_i.
  - If yumi_i=1 in N+1, nothing is stored.
  - Otherwise mem_data_i is enqueued at the end of N+1.
- In N+1 with the buffer non-empty: data_o=buffer head, and mem_data_i is enqueued at the end of N+1.
- Ordering: responses are strictly in request order, FIFO.
- Back-to-back reads with the consumer always yumi-ing: one response per cycle, 1-cycle latency, buffer stays empty.
- Consumer stalled: at most 2 reads outstanding (buffer full, or 1 buffered + 1 in flight), after which ready_and_o=0.
- Simultaneous enqueue and dequeue in the same cycle is allowed at any occupancy; the buffer count is unchanged.
- Reset asserted mid-operation: the in-flight read and buffered data are discarded, with no response emitted.

Optional Feature:
- Macro: BSG_MEM_1RW_RV_WRITE_ACK_EN.
- Defined:
  - Writes consume a credit like reads.
  - Each write produces one response 1 cycle later with data_o = all zeros, in order with read responses.
- Undefined: writes are silent and creditless, as described above.

Decomposition:
- Package bsg_mem_rv_pkg holds:
  - the localparam for response buffer depth (2);
  - an enum for the in-flight kind (e_rv_read, e_rv_write), used only under the macro.
- Sub-module bsg_mem_rv_resp_fifo: 2-entry 1r1w buffer with v/ready enqueue and v/yumi dequeue, plus a count output.
- The top level holds the credit logic, inflight_r and the bypass mux.

Test Plan:
- Write addr 5, data 0xAABBCCDD, mask 4'b1111; read addr 5 next cycle -> v_o=1 one cycle after the read with 0xAABBCCDD.
- Partial write mask 4'b0101, data 0x11223344, to a word holding 0xAABBCCDD -> read returns 0xAA22CC44.
- Reads to addrs 1,2,3 with yumi_i=0:
  - ready_and_o drops after 2 accepts;
  - after yumi, ordered data for addrs 1,2 then 3 is accepted and returned.
- Continuous reads of addrs 0..15 with yumi_i=1 -> 16 responses on consecutive cycles, latency 1, ready_and_o never drops.
- Two reads outstanding, then reset_i pulsed for 1 cycle -> v_o=0 after reset, ready_and_o=1, no stale response.
- Macro defined: write followed by read with yumi_i=1 -> response zeros, then the read data, in order.
